render_background: RTL and testbench

Fills the 160x120 rgb333 framebuffer with the scrolled background layer of the side-scroller. Each frame it walks every framebuffer pixel, looks up the tile index in the tilemap RAM, fetches the tile texel from the tile ROM, and writes it into the framebuffer RAM. It sits directly upstream of `drawScreen`, which reads the same framebuffer and pushes it to the VGA adapter. The top-level sequencer alternates the two blocks with Start/Done handshakes.

---
 rtl/screen_pkg.sv | 18 +
 rtl/fb_scan_counter.sv | 31 +++
 rtl/render_background.sv | 73 +++++++
 tb/tb_render_background.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/screen_pkg.sv
// Framebuffer and tile geometry shared by render_background and drawScreen.
package screen_pkg;
    localparam int SCREEN_W   = 160;
    localparam int SCREEN_H   = 120;
    localparam int FB_PIXELS  = 19200;
    localparam int TILE_SHIFT = 3;
    localparam int MAP_COLS   = 64;
    localparam int MAP_ROWS   = 15;

    typedef logic [8:0] rgb333_t;

    typedef enum logic [1:0] {
        RS_IDLE       = 2'd0,
        RS_FETCH_MAP  = 2'd1,
        RS_FETCH_TILE = 2'd2,
        RS_WRITE      = 2'd3
    } render_state_t;
endpackage

// File: rtl/fb_scan_counter.sv
// Raster scan position over the framebuffer: x/y plus the linear write address.
module fb_scan_counter
    import screen_pkg::*;
(
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        clear,
    input  logic        advance,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [14:0] lin,
    output logic        last
);
    assign last = (x == 8'(SCREEN_W - 1)) && (y == 7'(SCREEN_H - 1));

    always_ff @(posedge Clock) begin
        if (!Resetn || clear) begin
            x   <= '0;
            y   <= '0;
            lin <= '0;
        end else if (advance) begin
            lin <= lin + 15'd1;
            if (x == 8'(SCREEN_W - 1)) begin
                x <= '0;
                y <= y + 7'd1;
            end else begin
                x <= x + 8'd1;
            end
        end
    end
endmodule

// File: rtl/render_background.sv
// Renders the horizontally scrolled tile layer into the framebuffer, one pixel
// every three cycles (map fetch, tile fetch, write).
module render_background
    import screen_pkg::*;
(
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Start,
    input  logic [8:0]    ScrollX,
    output logic [9:0]    MapAddress,
    input  logic [5:0]    MapData,
    output logic [11:0]   TileAddress,
    input  rgb333_t       TileData,
    output logic [14:0]   FB_Address,
    output rgb333_t       FB_Data,
    output logic          FB_We,
    output logic          Done
);
    render_state_t state, state_nxt;
    logic [8:0]  scroll_q;
    logic [8:0]  wx;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [14:0] lin;
    logic        last;
    logic        accept;

    assign accept = (state == RS_IDLE) && Start;

    fb_scan_counter u_scan (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .clear   (accept),
        .advance (state == RS_WRITE),
        .x       (x),
        .y       (y),
        .lin     (lin),
        .last    (last)
    );

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state    <= RS_IDLE;
            scroll_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) scroll_q <= ScrollX;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RS_IDLE:       if (Start) state_nxt = RS_FETCH_MAP;
            RS_FETCH_MAP:  state_nxt = RS_FETCH_TILE;
            RS_FETCH_TILE: state_nxt = RS_WRITE;
            RS_WRITE:      state_nxt = last ? RS_IDLE : RS_FETCH_MAP;
            default:       state_nxt = RS_IDLE;
        endcase
    end

    // 9-bit add wraps the 512-px world horizontally.
    assign wx = {1'b0, x} + scroll_q;

    // Tile field is masked outside FETCH_TILE so the address is quiet at reset.
    assign MapAddress  = {y[6:TILE_SHIFT], wx[8:TILE_SHIFT]};
    assign TileAddress = {(state == RS_FETCH_TILE) ? MapData : 6'd0,
                          y[TILE_SHIFT-1:0], wx[TILE_SHIFT-1:0]};
    assign FB_Address  = lin;
    assign FB_Data     = TileData;
    assign FB_We       = (state == RS_WRITE);
    assign Done        = (state == RS_IDLE);
endmodule

// File: tb/tb_render_background.sv
// Self-checking bench: cycle-indexed reference of the frame schedule plus
// directed boundary checks on a held-Start, scroll-change, reset scenario.
module tb_render_background;
    localparam int FRAME = 57600;

    logic        Clock = 1'b0;
    logic        Resetn, Start;
    logic [8:0]  ScrollX;
    logic [9:0]  MapAddress;
    logic [5:0]  MapData;
    logic [11:0] TileAddress;
    logic [8:0]  TileData;
    logic [14:0] FB_Address;
    logic [8:0]  FB_Data;
    logic        FB_We, Done;

    render_background dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .ScrollX(ScrollX),
        .MapAddress(MapAddress), .MapData(MapData),
        .TileAddress(TileAddress), .TileData(TileData),
        .FB_Address(FB_Address), .FB_Data(FB_Data), .FB_We(FB_We), .Done(Done)
    );

    always #5 Clock = ~Clock;

    int map_mem [1024];
    int rom     [4096];
    int checks = 0, errors = 0;
    int cyc = 0;
    int wr_cnt = 0, fb0 = -1, fb161 = -1;
    bit first_frame = 1'b1;
    bit cmp_en = 1'b0;

    // Reference frame tracker: active, cycle index within frame, latched scroll.
    bit m_active = 1'b0;
    int m_k = 0, m_sq = 0;

    initial begin
        for (int a = 0; a < 1024; a++) map_mem[a] = a % 64;
        for (int a = 0; a < 4096; a++) rom[a] = a % 512;
    end

    always @(posedge Clock) begin
        cyc <= cyc + 1;
        MapData  <= 6'(map_mem[MapAddress]);
        TileData <= 9'(rom[TileAddress]);
        if (!Resetn) m_active <= 1'b0;
        else if (!m_active) begin
            if (Start) begin m_active <= 1'b1; m_k <= 1; m_sq <= int'(ScrollX); end
        end else if (m_k == FRAME) m_active <= 1'b0;
        else m_k <= m_k + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors < 40) $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge Clock) begin
        int n, ph, x, y, wx, row, col, px, py, tile, taddr;
        if (cmp_en) begin
            if (!m_active) begin
                chk("idle_done", int'(Done), 1);
                chk("idle_we", int'(FB_We), 0);
            end else begin
                n = (m_k - 1) / 3;  ph = (m_k - 1) % 3;
                x = n % 160;        y = n / 160;
                wx = (x + m_sq) % 512;
                col = wx / 8; px = wx % 8; row = y / 8; py = y % 8;
                tile = map_mem[row*64 + col];
                taddr = tile*64 + py*8 + px;
                chk("busy_done", int'(Done), 0);
                chk("we", int'(FB_We), (ph == 2) ? 1 : 0);
                case (ph)
                    0: chk("map_addr", int'(MapAddress), row*64 + col);
                    1: chk("tile_addr", int'(TileAddress), taddr);
                    default: begin
                        chk("fb_addr", int'(FB_Address), n);
                        chk("fb_data", int'(FB_Data), rom[taddr]);
                    end
                endcase
            end
            if (FB_We && first_frame) begin
                wr_cnt++;
                if (FB_Address == 15'd0)   fb0   = int'(FB_Data);
                if (FB_Address == 15'd161) fb161 = int'(FB_Data);
            end
        end
    end

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge Clock);
    endtask

    initial begin
        int c0, d, c1;
        Resetn = 1'b0; Start = 1'b0; ScrollX = 9'd0;
        repeat (3) @(negedge Clock);
        cmp_en = 1'b1;
        chk("rst_done", int'(Done), 1);
        chk("rst_we", int'(FB_We), 0);
        chk("rst_fb_addr", int'(FB_Address), 0);
        chk("rst_map_addr", int'(MapAddress), 0);
        chk("rst_tile_addr", int'(TileAddress), 0);
        chk("rst_fb_data", int'(FB_Data), int'(TileData));

        // Frame 1: identity, Start held high; scroll changes mid-frame are ignored.
        Resetn = 1'b1; Start = 1'b1; ScrollX = 9'd0;
        c0 = cyc;
        wait_to(c0 + 3*1000);
        ScrollX = 9'($urandom_range(1, 510));
        wait_to(c0 + 57000);
        ScrollX = 9'd511;
        while (!Done && cyc < c0 + 60000) @(negedge Clock);
        if (!Done) begin
            chk("done_timeout", 0, 1);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
        d = cyc;
        first_frame = 1'b0;
        chk("done_cycle", d - c0, 57601);
        chk("write_count", wr_cnt, 19200);
        chk("fb0", fb0, 0);
        chk("fb161", fb161, 9);

        // Frame 2 starts immediately with scroll 511.
        @(negedge Clock);
        chk("done_one_cycle", int'(Done), 0);
        chk("wrap_col_x0", int'(MapAddress), 63);
        wait_to(d + 2);
        chk("wrap_px_x0", int'(TileAddress) % 8, 7);
        wait_to(d + 3);
        chk("b2b_first_we", int'(FB_We), 1);
        chk("b2b_first_addr", int'(FB_Address), 0);
        wait_to(d + 4);
        chk("wrap_col_x1", int'(MapAddress), 0);
        wait_to(d + 5);
        chk("wrap_px_x1", int'(TileAddress) % 8, 0);

        wait_to(d + 1 + 3*1280);
        chk("row_field", int'(MapAddress) / 64, 1);
        wait_to(d + 3 + 3*1280);
        chk("row_fb_addr", int'(FB_Address), 1280);

        // Reset during the write of pixel 5000.
        wait_to(d + 3 + 3*5000);
        chk("pre_rst_we", int'(FB_We), 1);
        chk("pre_rst_addr", int'(FB_Address), 5000);
        Resetn = 1'b0; Start = 1'b0;
        @(negedge Clock);
        chk("post_rst_we", int'(FB_We), 0);
        chk("post_rst_done", int'(Done), 1);
        Resetn = 1'b1;
        repeat ($urandom_range(2, 6)) @(negedge Clock);
        ScrollX = 9'($urandom);
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        c1 = cyc;
        wait_to(c1 + 2);
        chk("restart_we", int'(FB_We), 1);
        chk("restart_addr", int'(FB_Address), 0);
        repeat (300) @(negedge Clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
